// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg -- shared definitions for the MIPS multi-cycle control FSM.
// Contents: FSM state enum, instruction class enum, opcode/funct constants,
// and the pc_src encodings used on the datapath next-PC mux.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CL_NONE   = 3'd0,
    CL_RALU   = 3'd1,
    CL_IALU   = 3'd2,
    CL_BRANCH = 3'd3,
    CL_JUMP   = 3'd4,
    CL_JR     = 3'd5,
    CL_LOAD   = 3'd6,
    CL_STORE  = 3'd7
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_REG    = 2'd3;

endpackage

// File: rtl/mips_cpu_instr_class.sv
// mips_cpu_instr_class -- combinational instruction classifier.
// Ports: opcode[5:0], funct[5:0] in; cls (instruction class) and valid out.
// valid is low for any opcode/funct pair the control FSM does not execute.
module mips_cpu_instr_class
  import mips_cpu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    cls,
  output logic       valid
);

  // Decode opcode (and funct for R-type) into an execution class
  always_comb begin
    cls = CL_NONE;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_SLL, FN_SRL, FN_SRA, FN_ADDU, FN_SUBU, FN_AND,
          FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: cls = CL_RALU;
          FN_JR:                                  cls = CL_JR;
          default:                                cls = CL_NONE;
        endcase
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI,
      OP_ORI, OP_XORI, OP_LUI:                    cls = CL_IALU;
      OP_BEQ, OP_BNE:                             cls = CL_BRANCH;
      OP_J:                                       cls = CL_JUMP;
      OP_LW:                                      cls = CL_LOAD;
      OP_SW:                                      cls = CL_STORE;
      default:                                    cls = CL_NONE;
    endcase
    valid = (cls != CL_NONE);
  end

endmodule

// File: rtl/mips_cpu_control_fsm.sv
// mips_cpu_control_fsm -- multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Ports: clk, reset (sync, active-high); instr, waitrequest from memory;
// sig_branch, pc_next_zero from datapath; registered control strobes
// (mem_read, mem_write, addr_sel, ir_en, pc_en, pc_src, reg_write, reg_dst),
// ALU fields (alu_control, alu_opcode, alu_shamt, alu_immediate), and status
// (active, fault, state).
// Build option MIPS_CPU_WAITREQ_EN: when defined, memory accesses honour
// waitrequest and a stall counter forces a faulting HALT after STALL_LIMIT
// consecutive stalled cycles (0 = unlimited). When undefined every access
// completes in one cycle.
// All outputs are registered: each transition also sets the strobes for the
// state being entered, so sig_branch is sampled at the end of DECODE and
// pc_next_zero at the end of EXEC.
module mips_cpu_control_fsm
  import mips_cpu_pkg::*;
#(
  parameter int STALL_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        waitrequest,
  input  logic        sig_branch,
  input  logic        pc_next_zero,
  output logic        mem_read,
  output logic        mem_write,
  output logic        addr_sel,
  output logic        ir_en,
  output logic        pc_en,
  output logic        reg_write,
  output logic [1:0]  pc_src,
  output logic        reg_dst,
  output logic [5:0]  alu_control,
  output logic [5:0]  alu_opcode,
  output logic [4:0]  alu_shamt,
  output logic [15:0] alu_immediate,
  output logic        active,
  output logic        fault,
  output logic [2:0]  state
);

  state_t  state_r;
  iclass_t cls_s;
  logic    cls_valid_s;
  logic    access_s;
  logic    accept_s;
  logic    timeout_s;
  logic [9:0] unused_instr_s;

  assign state          = state_r;
  assign unused_instr_s = instr[25:16];

  // Classification works on the latched fields, valid from DECODE onward
  mips_cpu_instr_class u_class (
    .opcode (alu_opcode),
    .funct  (alu_control),
    .cls    (cls_s),
    .valid  (cls_valid_s)
  );

`ifdef MIPS_CPU_WAITREQ_EN
  localparam logic [31:0] LIMIT_C = 32'(STALL_LIMIT);
  logic [8:0] stall_r;
  logic [8:0] stall_inc_s;

  // Memory handshake status and saturating next stall count
  always_comb begin
    access_s = mem_read | mem_write;
    accept_s = access_s & ~waitrequest;
    if (stall_r == 9'h1FF) begin
      stall_inc_s = stall_r;
    end else begin
      stall_inc_s = stall_r + 9'd1;
    end
    timeout_s = access_s & waitrequest & (LIMIT_C != 32'd0) &
                ({23'd0, stall_inc_s} == LIMIT_C);
  end

  // Consecutive-stall counter, cleared whenever an access is not stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_r <= 9'd0;
    end else if (access_s & waitrequest) begin
      stall_r <= stall_inc_s;
    end else begin
      stall_r <= 9'd0;
    end
  end
`else
  logic        unused_waitreq_s;
  logic [31:0] unused_limit_s;

  // Every issued access completes in the cycle it is presented
  always_comb begin
    access_s         = mem_read | mem_write;
    accept_s         = access_s;
    timeout_s        = 1'b0;
    unused_waitreq_s = waitrequest;
    unused_limit_s   = 32'(STALL_LIMIT);
  end
`endif

  // Control FSM: state register plus registered strobes and ALU fields
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_FETCH;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      addr_sel      <= 1'b0;
      ir_en         <= 1'b0;
      pc_en         <= 1'b0;
      pc_src        <= PC_SRC_SEQ;
      reg_write     <= 1'b0;
      reg_dst       <= 1'b0;
      alu_opcode    <= 6'd0;
      alu_control   <= 6'd0;
      alu_shamt     <= 5'd0;
      alu_immediate <= 16'd0;
      active        <= 1'b1;
      fault         <= 1'b0;
    end else begin
      // strobes are single-cycle unless a branch below re-asserts them
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      addr_sel  <= 1'b0;
      ir_en     <= 1'b0;
      pc_en     <= 1'b0;
      pc_src    <= PC_SRC_SEQ;
      reg_write <= 1'b0;
      reg_dst   <= 1'b0;
      case (state_r)
        ST_FETCH: begin
          if (!mem_read) begin
            // first FETCH cycle after reset: issue the request
            mem_read <= 1'b1;
          end else if (accept_s) begin
            alu_opcode    <= instr[31:26];
            alu_control   <= instr[5:0];
            alu_shamt     <= instr[10:6];
            alu_immediate <= instr[15:0];
            ir_en         <= 1'b1;
            state_r       <= ST_DECODE;
          end else if (timeout_s) begin
            state_r <= ST_HALT;
            active  <= 1'b0;
            fault   <= 1'b1;
          end else begin
            mem_read <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (!cls_valid_s) begin
            state_r <= ST_HALT;
            active  <= 1'b0;
            fault   <= 1'b1;
          end else begin
            state_r <= ST_EXEC;
            case (cls_s)
              CL_BRANCH: begin
                pc_en  <= 1'b1;
                pc_src <= sig_branch ? PC_SRC_BRANCH : PC_SRC_SEQ;
              end
              CL_JUMP: begin
                pc_en  <= 1'b1;
                pc_src <= PC_SRC_JUMP;
              end
              CL_JR: begin
                pc_en  <= 1'b1;
                pc_src <= PC_SRC_REG;
              end
              default: begin
                pc_en <= 1'b0;
              end
            endcase
          end
        end
        ST_EXEC: begin
          case (cls_s)
            CL_RALU, CL_IALU: begin
              state_r   <= ST_WB;
              reg_write <= 1'b1;
              reg_dst   <= (cls_s == CL_RALU);
              pc_en     <= 1'b1;
            end
            CL_LOAD: begin
              state_r  <= ST_MEM;
              mem_read <= 1'b1;
              addr_sel <= 1'b1;
            end
            CL_STORE: begin
              // MEM is the last state of a store, so its PC update goes here
              state_r   <= ST_MEM;
              mem_write <= 1'b1;
              addr_sel  <= 1'b1;
              pc_en     <= 1'b1;
            end
            CL_BRANCH, CL_JUMP: begin
              state_r  <= ST_FETCH;
              mem_read <= 1'b1;
            end
            CL_JR: begin
              if (pc_next_zero) begin
                state_r <= ST_HALT;
                active  <= 1'b0;
              end else begin
                state_r  <= ST_FETCH;
                mem_read <= 1'b1;
              end
            end
            default: begin
              state_r <= ST_HALT;
              active  <= 1'b0;
              fault   <= 1'b1;
            end
          endcase
        end
        ST_MEM: begin
          if (accept_s) begin
            if (cls_s == CL_STORE) begin
              state_r  <= ST_FETCH;
              mem_read <= 1'b1;
            end else begin
              state_r   <= ST_WB;
              reg_write <= 1'b1;
              pc_en     <= 1'b1;
            end
          end else if (timeout_s) begin
            state_r <= ST_HALT;
            active  <= 1'b0;
            fault   <= 1'b1;
          end else begin
            mem_read  <= mem_read;
            mem_write <= mem_write;
            addr_sel  <= 1'b1;
          end
        end
        ST_WB: begin
          state_r  <= ST_FETCH;
          mem_read <= 1'b1;
        end
        ST_HALT: begin
          state_r <= ST_HALT;
        end
        default: begin
          state_r <= ST_HALT;
          active  <= 1'b0;
          fault   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_control_fsm.sv
// tb_mips_cpu_control_fsm -- self-checking bench for mips_cpu_control_fsm.
// A per-instruction reference model expands each instruction into the list
// of cycles it should occupy (state, strobes, ALU fields) from the
// instruction's class and the number of memory wait states, then drives the
// DUT and compares cycle by cycle. Works with or without MIPS_CPU_WAITREQ_EN.
module tb_mips_cpu_control_fsm;
  import mips_cpu_pkg::*;

  localparam int LIMIT = 4;
`ifdef MIPS_CPU_WAITREQ_EN
  localparam bit WQ = 1'b1;
`else
  localparam bit WQ = 1'b0;
`endif

  localparam int K_BAD = 0, K_RALU = 1, K_IALU = 2, K_BR = 3, K_J = 4,
                 K_JR = 5, K_LW = 6, K_SW = 7;

  typedef struct packed {
    logic [2:0] st;
    logic mr, mw, as, ir, pe;
    logic [1:0] ps;
    logic rw, rd, act, flt;
  } ctl_t;
  typedef struct packed {
    logic [5:0] op, fn;
    logic [4:0] sh;
    logic [15:0] im;
  } alu_t;
  typedef struct packed {
    ctl_t c;
    alu_t a;
    logic wr;
  } item_t;

  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] instr = 32'd0;
  logic waitrequest = 1'b0, sig_branch = 1'b0, pc_next_zero = 1'b0;
  logic mem_read, mem_write, addr_sel, ir_en, pc_en, reg_write, reg_dst;
  logic [1:0] pc_src;
  logic [5:0] alu_control, alu_opcode;
  logic [4:0] alu_shamt;
  logic [15:0] alu_immediate;
  logic active, fault;
  logic [2:0] state;

  int checks = 0, errors = 0;
  alu_t m_alu = '0;
  bit m_fault = 1'b0;
  bit h;
  ctl_t obs_c;
  alu_t obs_a;

  logic [5:0] ops [12] = '{6'h00, 6'h00, 6'h00, 6'h09, 6'h0C, 6'h0F,
                           6'h04, 6'h05, 6'h02, 6'h23, 6'h2B, 6'h0A};
  logic [5:0] fns [12] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                           6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08};

  mips_cpu_control_fsm #(.STALL_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .instr(instr), .waitrequest(waitrequest),
    .sig_branch(sig_branch), .pc_next_zero(pc_next_zero),
    .mem_read(mem_read), .mem_write(mem_write), .addr_sel(addr_sel),
    .ir_en(ir_en), .pc_en(pc_en), .reg_write(reg_write), .pc_src(pc_src),
    .reg_dst(reg_dst), .alu_control(alu_control), .alu_opcode(alu_opcode),
    .alu_shamt(alu_shamt), .alu_immediate(alu_immediate), .active(active),
    .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  assign obs_c = {state, mem_read, mem_write, addr_sel, ir_en, pc_en, pc_src,
                  reg_write, reg_dst, active, fault};
  assign obs_a = {alu_opcode, alu_control, alu_shamt, alu_immediate};

  // Instruction classes of the supported MIPS subset
  function automatic int cls_of(logic [5:0] op, logic [5:0] fn);
    case (op)
      6'h00: begin
        if (fn == 6'h08) return K_JR;
        if (fn inside {6'h00, 6'h02, 6'h03, 6'h21, 6'h23, 6'h24, 6'h25,
                       6'h26, 6'h27, 6'h2A, 6'h2B}) return K_RALU;
        return K_BAD;
      end
      6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: return K_IALU;
      6'h04, 6'h05: return K_BR;
      6'h02: return K_J;
      6'h23: return K_LW;
      6'h2B: return K_SW;
      default: return K_BAD;
    endcase
  endfunction

  function automatic item_t base(state_t st, alu_t a);
    item_t x = '0;
    x.c.st  = st;
    x.c.act = (st != ST_HALT);
    x.c.flt = m_fault;
    x.a     = a;
    x.wr    = 1'($urandom_range(0, 1));
    return x;
  endfunction

  task automatic step(input item_t x, input logic [31:0] ins, input logic sb,
                      input logic pnz, input string tag);
    @(negedge clk);
    checks++;
    assert (obs_c === x.c) else begin
      errors++;
      $error("FAIL %s ctl observed=%h expected=%h", tag, obs_c, x.c);
    end
    checks++;
    assert (obs_a === x.a) else begin
      errors++;
      $error("FAIL %s alu observed=%h expected=%h", tag, obs_a, x.a);
    end
    waitrequest  = x.wr;
    instr        = ins;
    sig_branch   = sb;
    pc_next_zero = pnz;
  endtask

  task automatic do_reset();
    item_t x;
    reset   = 1'b1;
    m_fault = 1'b0;
    m_alu   = '0;
    x = base(ST_FETCH, '0);
    step(x, instr, sig_branch, pc_next_zero, "reset");
    reset = 1'b0;
  endtask

  task automatic run_instr(input logic [31:0] ins, input logic sb, input logic pnz,
                           input int nf_in, input int nm_in, input int rst_at,
                           input string tag, output bit halted);
    item_t q[$];
    item_t x;
    alu_t na;
    int nf, nm, k;
    nf = WQ ? nf_in : 0;
    nm = WQ ? nm_in : 0;
    na = {ins[31:26], ins[5:0], ins[10:6], ins[15:0]};
    k  = cls_of(ins[31:26], ins[5:0]);
    halted = 1'b0;
    for (int i = 0; i < nf && i < LIMIT; i++) begin
      x = base(ST_FETCH, m_alu); x.c.mr = 1'b1; x.wr = 1'b1; q.push_back(x);
    end
    if (nf >= LIMIT) begin
      m_fault = 1'b1; halted = 1'b1;
    end else begin
      x = base(ST_FETCH, m_alu); x.c.mr = 1'b1; x.wr = 1'b0; q.push_back(x);
      m_alu = na;
      x = base(ST_DECODE, na); x.c.ir = 1'b1; q.push_back(x);
      case (k)
        K_BR, K_J, K_JR: begin
          x = base(ST_EXEC, na); x.c.pe = 1'b1;
          x.c.ps = (k == K_J) ? 2'd2 : (k == K_JR) ? 2'd3 : (sb ? 2'd1 : 2'd0);
          q.push_back(x);
          if (k == K_JR && pnz) halted = 1'b1;
        end
        K_RALU, K_IALU: begin
          q.push_back(base(ST_EXEC, na));
          x = base(ST_WB, na); x.c.rw = 1'b1; x.c.pe = 1'b1;
          x.c.rd = (k == K_RALU); q.push_back(x);
        end
        K_LW, K_SW: begin
          q.push_back(base(ST_EXEC, na));
          for (int i = 0; i < nm && i < LIMIT; i++) begin
            x = base(ST_MEM, na); x.c.as = 1'b1; x.wr = 1'b1;
            x.c.mr = (k == K_LW); x.c.mw = (k == K_SW);
            x.c.pe = (k == K_SW) && (i == 0); q.push_back(x);
          end
          if (nm >= LIMIT) begin
            m_fault = 1'b1; halted = 1'b1;
          end else begin
            x = base(ST_MEM, na); x.c.as = 1'b1; x.wr = 1'b0;
            x.c.mr = (k == K_LW); x.c.mw = (k == K_SW);
            x.c.pe = (k == K_SW) && (nm == 0); q.push_back(x);
            if (k == K_LW) begin
              x = base(ST_WB, na); x.c.rw = 1'b1; x.c.pe = 1'b1; q.push_back(x);
            end
          end
        end
        default: begin
          m_fault = 1'b1; halted = 1'b1;
        end
      endcase
    end
    if (halted) begin
      for (int i = 0; i < 3; i++) q.push_back(base(ST_HALT, m_alu));
    end
    for (int i = 0; i < q.size(); i++) begin
      x = q[i];
      if (!WQ) x.wr = 1'($urandom_range(0, 1));
      step(x, ins, sb, pnz, tag);
      if (i == rst_at) begin
        do_reset();
        halted = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    logic [31:0] ins;
    do_reset();
    run_instr(32'h00221821, 1'b0, 1'b0, 0, 0, -1, "addu", h); if (h) do_reset();
    run_instr(32'h10220003, 1'b1, 1'b0, 0, 0, -1, "beq_taken", h); if (h) do_reset();
    run_instr(32'h14220003, 1'b0, 1'b0, 1, 0, -1, "bne_not_taken", h); if (h) do_reset();
    run_instr(32'h8C230004, 1'b0, 1'b0, 0, 3, -1, "lw_wait3", h); if (h) do_reset();
    run_instr(32'hAC230008, 1'b0, 1'b0, 1, 1, -1, "sw", h); if (h) do_reset();
    run_instr(32'h08000010, 1'b0, 1'b0, 0, 0, -1, "j", h); if (h) do_reset();
    run_instr(32'h03E00008, 1'b0, 1'b0, 0, 0, -1, "jr", h); if (h) do_reset();
    run_instr(32'h24420001, 1'b0, 1'b0, 2, 0, -1, "addiu", h); if (h) do_reset();
    run_instr(32'h03E00008, 1'b0, 1'b1, 0, 0, -1, "jr_halt", h); if (h) do_reset();
    run_instr(32'h00221821, 1'b0, 1'b0, 10, 0, -1, "fetch_timeout", h); if (h) do_reset();
    run_instr(32'h00221821, 1'b0, 1'b0, 0, 0, -1, "after_reset", h); if (h) do_reset();
    run_instr(32'hFC000000, 1'b0, 1'b0, 0, 0, -1, "bad_opcode", h); if (h) do_reset();
    run_instr(32'h8C230004, 1'b0, 1'b0, 0, 3, WQ ? 4 : 3, "lw_reset_mid", h);
    if (h) do_reset();
    for (int n = 0; n < 200; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 9) != 0) begin
        ins[31:26] = ops[$urandom_range(0, 11)];
        if (ins[31:26] == 6'h00) ins[5:0] = fns[$urandom_range(0, 11)];
      end
      run_instr(ins, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 19) == 0) ? 5 : int'($urandom_range(0, 2)),
                ($urandom_range(0, 19) == 0) ? 5 : int'($urandom_range(0, 2)),
                -1, "random", h);
      if (h) do_reset();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
